// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// default data-memory depth.
package lsu_pkg;

  localparam int DMEM_DEPTH_DEF = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // Number of bytes touched by an access; 0 marks the illegal encoding.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store control stage (slave).
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational data path: load extraction with sign/zero extension, and the
// read-modify-write merge of store data into the word read from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rd,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [2:0] nbytes;

  assign nbytes = size_nbytes(size);

  // The memory word port starts at the access address, so lane 0 always holds
  // the lowest addressed byte; lanes beyond the access width keep old data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign store_data[8*gi +: 8] = (3'(gi) < nbytes) ? wdata[8*gi +: 8]
                                                       : rd[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    load_data = rd;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & rd[7]}}, rd[7:0]};
      SZ_HALF: load_data = {{16{~is_unsigned & rd[15]}}, rd[15:0]};
      default: load_data = rd;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of a byte-addressed data memory.
// Define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  lsu_ctrl_if.slave         req_bus,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int AW1 = ADDR_W + 1;

  lsu_state_e        state_reg, state_next;
  logic              we_reg;
  logic              uns_reg;
  logic              err_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rd_reg;

  logic              accept;
  logic              size_ill;
  logic              out_of_range;
  logic              misaligned;
  logic              req_fault;
  logic [AW1-1:0]    last_byte;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  assign req_bus.req_ready = (state_reg == IDLE) && reset;
  assign accept            = req_bus.req_valid && req_bus.req_ready;

  // One extra bit so that addresses near the top of the space cannot wrap
  // back into range.
  assign size_ill     = (req_bus.req_size == SZ_ILL);
  assign last_byte    = {1'b0, req_bus.req_addr}
                      + AW1'(size_nbytes(req_bus.req_size)) - AW1'(1);
  assign out_of_range = last_byte > AW1'(DMEM_DEPTH - 1);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((req_bus.req_size == SZ_HALF) && req_bus.req_addr[0])
                   || ((req_bus.req_size == SZ_WORD) && (req_bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_fault = size_ill || out_of_range || misaligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      err_reg   <= 1'b0;
      size_reg  <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= '0;
    end else begin
      if (accept) begin
        we_reg    <= req_bus.req_we;
        uns_reg   <= req_bus.req_unsigned;
        err_reg   <= req_fault;
        size_reg  <= req_bus.req_size;
        addr_reg  <= req_bus.req_addr;
        wdata_reg <= req_bus.req_wdata;
      end
      // Memory drives data_out on the negedge inside READ.
      if (state_reg == READ) begin
        rd_reg <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_fault) begin
            state_next = RESP;
          end else if (!req_bus.req_we) begin
            state_next = READ;
          end else if (req_bus.req_size == SZ_WORD) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ:    state_next = we_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_align u_align (
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .rd          (rd_reg),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // All memory and response outputs come from registered state only.
  always_comb begin
    mem_re            = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    req_bus.rsp_valid = 1'b0;
    req_bus.rsp_err   = 1'b0;
    req_bus.rsp_rdata = '0;
    case (state_reg)
      READ: begin
        mem_re   = 1'b1;
        mem_addr = addr_reg;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_reg;
        mem_wdata = store_data;
      end
      RESP: begin
        req_bus.rsp_valid = 1'b1;
        req_bus.rsp_err   = err_reg;
        if (!err_reg && !we_reg) begin
          req_bus.rsp_rdata = load_data;
        end
      end
      default: ;
    endcase
  end

endmodule
